dot_product_seq: RTL and testbench

DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

---
 rtl/dotp_pkg.sv | 14 +
 rtl/dotp_mac.sv | 50 +++++
 rtl/dot_product_seq.sv | 106 ++++++++++
 tb/tb_dot_product_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// Shared types and default widths for the sequential dot-product engine.
package dotp_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE
  } state_t;

endpackage

// File: rtl/dotp_mac.sv
// Multiply-accumulate datapath with sticky overflow.
// Defining DOTP_SAT_EN clamps the accumulator at all-ones on overflow; otherwise it wraps.
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RES_WIDTH  = 2*DEF_DATA_WIDTH + DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [RES_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam int PAD = RES_WIDTH + 1 - 2*DATA_WIDTH;

  logic [2*DATA_WIDTH-1:0] prod;
  logic [RES_WIDTH:0]      sum;
  logic [RES_WIDTH-1:0]    acc_next;

  // Operands are widened first so the product is computed at full precision.
  assign prod = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
  assign sum  = {1'b0, acc} + {{PAD{1'b0}}, prod};

`ifdef DOTP_SAT_EN
  assign acc_next = sum[RES_WIDTH] ? '1 : sum[RES_WIDTH-1:0];
`else
  assign acc_next = sum[RES_WIDTH-1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (valid) begin
      acc <= acc_next;
      ovf <= ovf | sum[RES_WIDTH];
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Sequential dot product: reads A/B element pairs, accumulates, writes one result.
// Optional macro DOTP_SAT_EN selects saturating accumulation inside dotp_mac.
module dot_product_seq
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RES_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len_m1,
  input  logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  op_read_en,
  output logic [ADDR_WIDTH-1:0] op_read_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  res_write_en,
  output logic [ADDR_WIDTH-1:0] res_write_address,
  output logic [RES_WIDTH-1:0]  res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, len_q, addr_q;
  logic                  valid_q;
  logic                  rd_en, wr_en, accept;
  logic [RES_WIDTH-1:0]  acc;
  logic                  ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      valid_q <= rd_en;
      if (accept) begin
        cnt    <= '0;
        len_q  <= len_m1;
        addr_q <= res_addr;
      end else if (state == READ) begin
        cnt <= cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (cnt == len_q) state_next = DRAIN;
      end
      DRAIN: state_next = WRITE;
      WRITE: begin
        wr_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  dotp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WIDTH  (RES_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .valid  (valid_q),
    .a_data (a_data),
    .b_data (b_data),
    .acc    (acc),
    .ovf    (ovf_q)
  );

  // Outputs are qualified by rst_n so they read zero for the whole reset
  // window, including before the first clock edge; buses idle at zero.
  assign op_read_en        = rst_n & rd_en;
  assign op_read_address   = (rst_n && rd_en) ? cnt : '0;
  assign res_write_en      = rst_n & wr_en;
  assign done              = rst_n & wr_en;
  assign res_write_address = (rst_n && wr_en) ? addr_q : '0;
  assign res_data          = (rst_n && wr_en) ? acc : '0;
  assign busy              = rst_n && (state != IDLE);
  assign ovf               = rst_n & ovf_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench: default-width and 16-bit-result instances share stimulus and memories.
module tb_dot_product_seq;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int RW   = 2*DW + AW;
  localparam int RW16 = 16;
`ifdef DOTP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk, rst_n, start;
  logic [AW-1:0] len_m1, res_addr;
  logic [DW-1:0] a_data, b_data;

  logic          rd_en, wr_en, busy, done, ovf;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [RW-1:0] res_data;
  logic            rd_en16, wr_en16, busy16, done16, ovf16;
  logic [AW-1:0]   rd_addr16, wr_addr16;
  logic [RW16-1:0] res_data16;

  dot_product_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .res_addr(res_addr),
    .op_read_en(rd_en), .op_read_address(rd_addr), .a_data(a_data), .b_data(b_data),
    .res_write_en(wr_en), .res_write_address(wr_addr), .res_data(res_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  dot_product_seq #(.RES_WIDTH(RW16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .res_addr(res_addr),
    .op_read_en(rd_en16), .op_read_address(rd_addr16), .a_data(a_data), .b_data(b_data),
    .res_write_en(wr_en16), .res_write_address(wr_addr16), .res_data(res_data16),
    .busy(busy16), .done(done16), .ovf(ovf16)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [16];

  // Reference model state: one job described by start cycle, length and partial sums.
  bit     job_v;
  int     job_t, job_len, job_addr;
  longint ps [17];

  // Expected values for the current cycle.
  bit     e_rd, e_wr, e_busy;
  int     e_ra, e_wa;
  longint e_part, e_tot;

  // Observations gathered by the compare process.
  int     wr_cnt = 0, rd_cnt = 0;
  int     last_cyc = 0, prev_cyc = 0;
  longint last_data = 0, wr16_data = 0;
  int     last_addr = 0;
  bit     last_ovf = 0, wr16_ovf = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint model_res(input longint total, input int w);
    longint lim;
    lim = longint'(1) << w;
    if (total >= lim) return SAT ? lim - 1 : total % lim;
    return total;
  endfunction

  task automatic cmp_dut(input string tag, input int w, input logic rd, input logic [AW-1:0] ra,
                         input logic wr, input logic [AW-1:0] wa, input logic [63:0] rdata,
                         input logic bsy, input logic dn, input logic ov);
    check({tag, "op_read_en"}, rd, e_rd);
    check({tag, "op_read_address"}, ra, e_ra);
    check({tag, "res_write_en"}, wr, e_wr);
    check({tag, "done"}, dn, e_wr);
    check({tag, "res_write_address"}, wa, e_wa);
    check({tag, "res_data"}, rdata, e_wr ? model_res(e_tot, w) : 0);
    check({tag, "busy"}, bsy, e_busy);
    check({tag, "ovf"}, ov, e_part >= (longint'(1) << w));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Operand memories: one-cycle read latency, junk on the bus when not read.
  initial begin
    bit          pend;
    logic [AW-1:0] ad;
    a_data = '0;
    b_data = '0;
    forever begin
      @(negedge clk);
      pend = rd_en;
      ad   = rd_addr;
      @(posedge clk);
      #1;
      if (pend) begin
        a_data = a_mem[ad];
        b_data = b_mem[ad];
      end else begin
        a_data = DW'($urandom);
        b_data = DW'($urandom);
      end
    end
  end

  // Compare process: every cycle, both instances against the model.
  initial begin
    int ph, nacc;
    job_v = 1'b0;
    forever begin
      @(negedge clk);
      e_rd = 0; e_wr = 0; e_busy = 0; e_ra = 0; e_wa = 0; e_part = 0; e_tot = 0;
      if (rst_n && job_v) begin
        ph     = cyc - job_t;
        e_busy = (ph >= 1) && (ph <= job_len + 3);
        e_rd   = (ph >= 1) && (ph <= job_len + 1);
        e_ra   = e_rd ? ph - 1 : 0;
        e_wr   = (ph == job_len + 3);
        e_wa   = e_wr ? job_addr : 0;
        nacc   = ph - 2;
        if (nacc < 0) nacc = 0;
        if (nacc > job_len + 1) nacc = job_len + 1;
        e_part = ps[nacc];
        e_tot  = ps[job_len + 1];
      end
      cmp_dut("w20.", RW, rd_en, rd_addr, wr_en, wr_addr, 64'(res_data), busy, done, ovf);
      cmp_dut("w16.", RW16, rd_en16, rd_addr16, wr_en16, wr_addr16, 64'(res_data16),
              busy16, done16, ovf16);

      if (rd_en) rd_cnt++;
      if (wr_en) begin
        wr_cnt++;
        prev_cyc  = last_cyc;
        last_cyc  = cyc;
        last_data = longint'(res_data);
        last_addr = int'(wr_addr);
        last_ovf  = ovf;
      end
      if (wr_en16) begin
        wr16_data = longint'(res_data16);
        wr16_ovf  = ovf16;
      end

      if (!rst_n) begin
        job_v = 1'b0;
      end else if (start && (!job_v || (cyc - job_t > job_len + 3))) begin
        job_v    = 1'b1;
        job_t    = cyc;
        job_len  = int'(len_m1);
        job_addr = int'(res_addr);
        ps[0]    = 0;
        for (int k = 0; k <= job_len; k++)
          ps[k+1] = ps[k] + longint'(a_mem[k]) * longint'(b_mem[k]);
      end
    end
  end

  task automatic wait_done(input int w0, input int budget);
    int n = 0;
    while (wr_cnt == w0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_write_timeout", wr_cnt != w0, 1);
  endtask

  int t_start, rd0, w0;

  task automatic run_job(input int len, input int addr);
    len_m1   = AW'(len);
    res_addr = AW'(addr);
    @(posedge clk); #1;
    start   = 1'b1;
    t_start = cyc;
    rd0     = rd_cnt;
    w0      = wr_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(w0, 40);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = DW'(i + 1);
      b_mem[i] = DW'(i + 5);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len_m1 = '0; res_addr = '0;
    for (int i = 0; i < 16; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_res_data", res_data, 0);
    check("reset_ovf", ovf, 0);
    rst_n = 1'b1;

    // Basic 4-element product: 1*5+2*6+3*7+4*8 = 70.
    load_ramp();
    run_job(3, 2);
    check("r038_data", last_data, 70);
    check("r038_addr", last_addr, 2);
    check("r038_latency", last_cyc - t_start, 6);
    check("r038_ovf", last_ovf, 0);

    // Single element at operand maximum.
    a_mem[0] = 8'd255; b_mem[0] = 8'd255;
    run_job(0, 5);
    check("r039_data", last_data, 65025);
    check("r039_latency", last_cyc - t_start, 3);
    check("r039_reads", rd_cnt - rd0, 1);
    check("r039_ovf16", wr16_ovf, 0);

    // Start pulsed mid-READ is ignored.
    load_ramp();
    len_m1 = 4'd3; res_addr = 4'd4;
    @(posedge clk); #1; start = 1'b1; t_start = cyc; w0 = wr_cnt;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(w0, 40);
    check("r040_data", last_data, 70);
    check("r040_latency", last_cyc - t_start, 6);
    repeat (8) @(posedge clk);
    #1;
    check("r040_single_write", wr_cnt - w0, 1);

    // Reset during the second READ cycle aborts without a write.
    len_m1 = 4'd3; res_addr = 4'd6;
    @(posedge clk); #1; start = 1'b1; w0 = wr_cnt;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("r041_idle_after_reset", busy, 0);
    repeat (8) @(posedge clk);
    #1;
    check("r041_no_write", wr_cnt - w0, 0);
    run_job(3, 9);
    check("r041_restart_data", last_data, 70);
    check("r041_restart_addr", last_addr, 9);

    // Two 255*255 terms: 130050 fits 20 bits, overflows 16 bits.
    a_mem[0] = 8'd255; a_mem[1] = 8'd255; b_mem[0] = 8'd255; b_mem[1] = 8'd255;
    run_job(1, 1);
    check("r042_data20", last_data, 130050);
    check("r042_ovf20", last_ovf, 0);
    check("r042_data16", wr16_data, SAT ? 65535 : 64514);
    check("r042_ovf16", wr16_ovf, 1);

    // Maximum length, all operands at maximum: 16*65025 = 1040400.
    for (int i = 0; i < 16; i++) begin a_mem[i] = 8'd255; b_mem[i] = 8'd255; end
    run_job(15, 15);
    check("maxlen_data20", last_data, 1040400);
    check("maxlen_latency", last_cyc - t_start, 18);
    check("maxlen_reads", rd_cnt - rd0, 16);
    check("maxlen_ovf16", wr16_ovf, 1);

    // Start held high: the next job is accepted in the IDLE cycle after WRITE.
    load_ramp();
    len_m1 = 4'd3; res_addr = 4'd7;
    @(posedge clk); #1; start = 1'b1; t_start = cyc; w0 = wr_cnt;
    wait_done(w0, 40);
    check("r043_first_latency", last_cyc - t_start, 6);
    w0 = wr_cnt;
    wait_done(w0, 40);
    start = 1'b0;
    check("r043_spacing", last_cyc - prev_cyc, 7);
    check("r043_data", last_data, 70);
    repeat (10) @(posedge clk);
    #1;
    check("r043_stopped", wr_cnt - w0, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
